// File: rtl/layer_visible_arbiter.sv
// Per-pixel layer arbiter: masks and blinks the layer hit requests, then registers a
// fixed-priority one-hot select for the RGB mux. New configuration takes effect at frame start.
module layer_visible_arbiter #(
  parameter int NUM_LAYERS   = 6,
  parameter int BLINK_FRAMES = 30,
  parameter int CNT_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_en,
  input  logic                  vsync_start,
  input  logic [NUM_LAYERS-1:0] hit,
  input  logic [NUM_LAYERS-1:0] cfg_mask,
  input  logic [NUM_LAYERS-1:0] cfg_blink,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [NUM_LAYERS-1:0] visible,
  output logic                  collision,
  output logic                  blink_phase
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  // Handshake: a configuration transfers on a clk edge where cfg_valid and cfg_ready are both
  // high. cfg_ready is low while a transferred configuration waits for the next frame start.
  logic                  pend_flag_q, pend_flag_d;
  logic [NUM_LAYERS-1:0] pend_mask_q, pend_mask_d;
  logic [NUM_LAYERS-1:0] pend_blink_q, pend_blink_d;
  logic [NUM_LAYERS-1:0] act_mask_q, act_mask_d;
  logic [NUM_LAYERS-1:0] act_blink_q, act_blink_d;
  logic [CNT_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [NUM_LAYERS-1:0] visible_q, visible_d;
  logic                  collision_q, collision_d;

  logic                  cfg_xfer;
  logic                  cfg_apply;
  logic [NUM_LAYERS-1:0] eff;
  logic [NUM_LAYERS-1:0] winner;
  logic                  multi_hit;

  assign cfg_xfer  = cfg_valid & ~pend_flag_q;
  assign cfg_apply = vsync_start & pend_flag_q;

  // Request path always sees the configuration and phase from before the current edge.
  assign eff       = hit & act_mask_q & ~(act_blink_q & {NUM_LAYERS{blink_phase_q}});
  assign winner    = eff & (~eff + NUM_LAYERS'(1));
  assign multi_hit = |(eff & (eff - NUM_LAYERS'(1)));

  always_comb begin
    pend_flag_d  = pend_flag_q;
    pend_mask_d  = pend_mask_q;
    pend_blink_d = pend_blink_q;
    act_mask_d   = act_mask_q;
    act_blink_d  = act_blink_q;
    // Apply and capture are exclusive: capture needs the flag clear, apply needs it set.
    if (cfg_apply) begin
      act_mask_d  = pend_mask_q;
      act_blink_d = pend_blink_q;
      pend_flag_d = 1'b0;
    end else if (cfg_xfer) begin
      pend_mask_d  = cfg_mask;
      pend_blink_d = cfg_blink;
      pend_flag_d  = 1'b1;
    end
  end

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (vsync_start) begin
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    visible_d   = visible_q;
    collision_d = collision_q;
    if (pix_en) begin
      visible_d   = winner;
      collision_d = multi_hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_flag_q   <= 1'b0;
      pend_mask_q   <= '0;
      pend_blink_q  <= '0;
      act_mask_q    <= '1;
      act_blink_q   <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      visible_q     <= '0;
      collision_q   <= 1'b0;
    end else begin
      pend_flag_q   <= pend_flag_d;
      pend_mask_q   <= pend_mask_d;
      pend_blink_q  <= pend_blink_d;
      act_mask_q    <= act_mask_d;
      act_blink_q   <= act_blink_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      visible_q     <= visible_d;
      collision_q   <= collision_d;
    end
  end

  assign cfg_ready   = ~pend_flag_q;
  assign visible     = visible_q;
  assign collision   = collision_q;
  assign blink_phase = blink_phase_q;

endmodule
